// File: rtl/lb_config_sequencer.sv
// Line-buffer sequencer for one memory_core tile: turns host commands into
// config writes, flush pulses and clock-gated SRAM readbacks.
module lb_config_sequencer #(
  parameter int         FLUSH_CYCLES = 3,
  parameter int         GATE_CYCLES  = 5,
  parameter int         READ_CYCLES  = 5,
  parameter logic [7:0] SRAM_ADDR_HI = 8'h07
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  input  logic [15:0] mem_read_data,
  output logic        mem_clk_en,
  output logic        mem_config_en,
  output logic        mem_config_write,
  output logic        mem_config_read,
  output logic [3:0]  mem_config_en_sram,
  output logic [31:0] mem_config_addr,
  output logic [31:0] mem_config_data,
  output logic        mem_flush,
  output logic        stream_en,
  output logic        busy
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE, CFG, SETTLE, RUN, FLUSH, RD_GATE, RD_ISSUE, RD_RESUME
  } state_t;

  state_t           state;
  logic             origin_run;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rd_bank;
  logic [9:0]       rd_word;

  // Bits above the depth field carry no meaning for any command.
  logic unused_arg;
  assign unused_arg = ^cmd_arg[15:13];

  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      origin_run         <= 1'b0;
      cnt                <= '0;
      rd_bank            <= '0;
      rd_word            <= '0;
      cmd_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_data           <= '0;
      mem_clk_en         <= 1'b1;
      mem_config_en      <= 1'b0;
      mem_config_write   <= 1'b0;
      mem_config_read    <= 1'b0;
      mem_config_en_sram <= '0;
      mem_config_addr    <= '0;
      mem_config_data    <= '0;
      mem_flush          <= 1'b0;
      stream_en          <= 1'b0;
      busy               <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE, RUN: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            origin_run <= (state == RUN);
            case (cmd_op)
              2'd0: begin
                state            <= CFG;
                cmd_ready        <= 1'b0;
                busy             <= 1'b1;
                stream_en        <= 1'b0;
                mem_config_en    <= 1'b1;
                mem_config_write <= 1'b1;
                mem_config_addr  <= '0;
                mem_config_data  <= {16'b0, cmd_arg[12:0], 1'b1, 2'b00};
              end
              2'd1: begin
                state     <= FLUSH;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
                mem_flush <= 1'b1;
                cnt       <= cnt_load(FLUSH_CYCLES);
              end
              2'd2: begin
                state      <= RD_GATE;
                cmd_ready  <= 1'b0;
                busy       <= 1'b1;
                stream_en  <= 1'b0;
                mem_clk_en <= 1'b0;
                rd_bank    <= cmd_arg[11:10];
                rd_word    <= cmd_arg[9:0];
                cnt        <= cnt_load(GATE_CYCLES);
              end
              default: ;
            endcase
          end
        end
        CFG: begin
          state            <= SETTLE;
          mem_config_en    <= 1'b0;
          mem_config_write <= 1'b0;
          mem_config_data  <= '0;
        end
        SETTLE: begin
          state     <= RUN;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          stream_en <= 1'b1;
        end
        FLUSH: begin
          if (cnt == '0) begin
            state     <= origin_run ? RUN : IDLE;
            mem_flush <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_GATE: begin
          if (cnt == '0) begin
            state              <= RD_ISSUE;
            mem_config_read    <= 1'b1;
            mem_config_en_sram <= 4'b0001 << rd_bank;
            mem_config_addr    <= {SRAM_ADDR_HI, 14'b0, rd_word};
            cnt                <= cnt_load(READ_CYCLES);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_ISSUE: begin
          // Read data is only trusted once the strobe has been held the full window.
          if (cnt == '0) begin
            state              <= RD_RESUME;
            rsp_data           <= mem_read_data;
            rsp_valid          <= 1'b1;
            mem_config_read    <= 1'b0;
            mem_config_en_sram <= '0;
            mem_config_addr    <= '0;
            cnt                <= cnt_load(GATE_CYCLES);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RESUME: begin
          if (cnt == '0) begin
            state      <= origin_run ? RUN : IDLE;
            mem_clk_en <= 1'b1;
            stream_en  <= origin_run;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_config_sequencer.sv
// Directed and randomised checks for lb_config_sequencer.
module tb_lb_config_sequencer;

  localparam int FLUSH = 3;
  localparam int GATE  = 5;
  localparam int READ  = 5;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] mem_read_data;
  logic        mem_clk_en;
  logic        mem_config_en;
  logic        mem_config_write;
  logic        mem_config_read;
  logic [3:0]  mem_config_en_sram;
  logic [31:0] mem_config_addr;
  logic [31:0] mem_config_data;
  logic        mem_flush;
  logic        stream_en;
  logic        busy;

  int checks = 0;
  int errors = 0;

  lb_config_sequencer #(
    .FLUSH_CYCLES(FLUSH), .GATE_CYCLES(GATE), .READ_CYCLES(READ), .SRAM_ADDR_HI(8'h07)
  ) dut (
    .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_read_data(mem_read_data), .mem_clk_en(mem_clk_en), .mem_config_en(mem_config_en),
    .mem_config_write(mem_config_write), .mem_config_read(mem_config_read),
    .mem_config_en_sram(mem_config_en_sram), .mem_config_addr(mem_config_addr),
    .mem_config_data(mem_config_data), .mem_flush(mem_flush), .stream_en(stream_en),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected flags order: ready busy stream clk_en cfg_en cfg_write flush
  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [15:0] arg;
    logic [6:0]  flags;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[15];

  task automatic readback(input logic [15:0] arg, input logic [3:0] exp_sram,
                          input logic [31:0] exp_addr, input logic exp_stream);
    int off = 0;
    int rd = 0;
    int rsp = 0;
    int rsp_at = -1;
    int bad = 0;
    int cyc = 0;
    logic [15:0] got = '0;
    @(negedge clk_in);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = arg; mem_read_data = 16'h1234;
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
    while (mem_clk_en == 1'b0 && cyc < 40) begin
      off++;
      if (stream_en || mem_config_en || mem_config_write || mem_flush) bad++;
      if (mem_config_read) begin
        rd++;
        if (mem_config_en_sram !== exp_sram || mem_config_addr !== exp_addr) bad++;
      end else if (mem_config_en_sram != 4'b0 || mem_config_addr != 32'h0) begin
        bad++;
      end
      if (rsp_valid) begin
        rsp++; rsp_at = off; got = rsp_data;
      end
      mem_read_data = (mem_config_read && rd == READ) ? 16'h00AB : 16'h1234;
      @(posedge clk_in); #1;
      cyc++;
    end
    chk("rd_clk_off_cycles", 80'(off), 80'(2 * GATE + READ));
    chk("rd_read_cycles", 80'(rd), 80'(READ));
    chk("rd_strobe_errors", 80'(bad), 80'(0));
    chk("rd_rsp_count", 80'(rsp), 80'(1));
    chk("rd_rsp_timing", 80'(rsp_at), 80'(GATE + READ + 1));
    chk("rd_rsp_data", 80'(got), 80'(16'h00AB));
    chk("rd_after", 80'({mem_clk_en, stream_en, busy, cmd_ready, rsp_valid, rsp_data}),
        80'({1'b1, exp_stream, 1'b0, 1'b1, 1'b0, 16'h00AB}));
  endtask

  initial begin
    logic [6:0] act7;
    int m_left, m_kind;
    logic m_ready, m_stream, m_after, m_clk, m_flush, v_s;
    logic [1:0] op_s;

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 16'h0; mem_read_data = 16'h0;

    tbl[0]  = '{1'b0, 2'd0, 16'h0000, 7'b1001000, 32'h0};
    tbl[1]  = '{1'b1, 2'd0, 16'h000A, 7'b0101110, 32'h0000_0054};
    tbl[2]  = '{1'b0, 2'd0, 16'h0000, 7'b0101000, 32'h0};
    tbl[3]  = '{1'b0, 2'd0, 16'h0000, 7'b1011000, 32'h0};
    tbl[4]  = '{1'b1, 2'd1, 16'h0000, 7'b0111001, 32'h0};
    tbl[5]  = '{1'b1, 2'd0, 16'h000A, 7'b0111001, 32'h0};
    tbl[6]  = '{1'b0, 2'd0, 16'h0000, 7'b0111001, 32'h0};
    tbl[7]  = '{1'b0, 2'd0, 16'h0000, 7'b1011000, 32'h0};
    tbl[8]  = '{1'b1, 2'd3, 16'hFFFF, 7'b1011000, 32'h0};
    tbl[9]  = '{1'b1, 2'd0, 16'hFFFF, 7'b0101110, 32'h0000_FFFC};
    tbl[10] = '{1'b0, 2'd0, 16'h0000, 7'b0101000, 32'h0};
    tbl[11] = '{1'b0, 2'd0, 16'h0000, 7'b1011000, 32'h0};
    tbl[12] = '{1'b1, 2'd0, 16'h0000, 7'b0101110, 32'h0000_0004};
    tbl[13] = '{1'b0, 2'd0, 16'h0000, 7'b0101000, 32'h0};
    tbl[14] = '{1'b0, 2'd0, 16'h0000, 7'b1011000, 32'h0};

    #12;
    chk("reset_outputs",
        80'({cmd_ready, busy, stream_en, mem_clk_en, mem_config_en, mem_config_write,
             mem_flush, mem_config_read, rsp_valid, mem_config_en_sram, rsp_data}),
        80'({7'b0001000, 1'b0, 1'b0, 4'b0, 16'h0}));
    @(negedge clk_in);
    reset = 1'b1;

    // Configure, flush on first RUN cycle, op 3, reconfigure from RUN
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      cmd_valid = tbl[i].v; cmd_op = tbl[i].op; cmd_arg = tbl[i].arg;
      @(posedge clk_in); #1;
      act7 = {cmd_ready, busy, stream_en, mem_clk_en, mem_config_en, mem_config_write, mem_flush};
      chk($sformatf("vec%0d", i),
          80'({act7, mem_config_read, mem_config_addr, mem_config_data}),
          80'({tbl[i].flags, 1'b0, 32'h0, tbl[i].data}));
    end
    @(negedge clk_in);
    cmd_valid = 1'b0;

    readback(16'h0805, 4'b0100, 32'h0700_0005, 1'b1);

    // Reset in the middle of a readback
    @(negedge clk_in);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 16'h0805;
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #2;
    chk("pre_reset_clk_off", 80'(mem_clk_en), 80'(1'b0));
    reset = 1'b0;
    #1;
    chk("async_reset",
        80'({mem_clk_en, cmd_ready, busy, stream_en, rsp_valid, mem_config_read, rsp_data}),
        80'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}));
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    chk("ready_before_edge", 80'(cmd_ready), 80'(1'b0));
    @(posedge clk_in); #1;
    chk("ready_after_release", 80'({cmd_ready, busy, stream_en, mem_clk_en, rsp_valid}),
        80'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));

    readback(16'h0C3F, 4'b1000, 32'h0700_003F, 1'b0);

    // Random traffic against a command-duration model
    m_left = 0; m_kind = 0; m_ready = 1'b1; m_stream = 1'b0; m_after = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom_range(0, 3));
      cmd_arg = 16'($urandom);
      mem_read_data = 16'($urandom);
      v_s = cmd_valid; op_s = cmd_op;
      @(posedge clk_in); #1;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ready = 1'b1; m_stream = m_after; m_kind = 0;
        end
      end else if (v_s && m_ready) begin
        case (op_s)
          2'd0: begin m_left = 2; m_kind = 1; m_ready = 1'b0; m_after = 1'b1; m_stream = 1'b0; end
          2'd1: begin m_left = FLUSH; m_kind = 2; m_ready = 1'b0; m_after = m_stream; end
          2'd2: begin m_left = 2 * GATE + READ; m_kind = 3; m_ready = 1'b0; m_after = m_stream; m_stream = 1'b0; end
          default: ;
        endcase
      end
      m_flush = (m_kind == 2) && (m_left > 0);
      m_clk = !((m_kind == 3) && (m_left > 0));
      chk($sformatf("rand%0d", i), 80'({cmd_ready, busy, stream_en, mem_clk_en, mem_flush}),
          80'({m_ready, !m_ready, m_stream, m_clk, m_flush}));
      chk($sformatf("rand_inv%0d", i),
          80'((!mem_clk_en && (mem_config_en || mem_config_write || mem_flush)) ||
              (mem_config_write && mem_config_read)), 80'(1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lb_config_sequencer.md
Name: lb_config_sequencer

Overview:
- Controller that sequences one memory_core tile used as a line buffer.
- Converts single host commands into the memory core's cycle-level control: configure, enable streaming, flush, and debug SRAM readback.
- SRAM readback is done with the tile clock gated off.
- Sits between the tile-level host/config bus and the memory core's config, clk_en and flush pins.
- Owns the stream-enable that gates the upstream producer.

Parameters:
- FLUSH_CYCLES, 3: cycles mem_flush is held high per flush command (≥1).
- GATE_CYCLES, 5: settle cycles after clk_en falls and before clk_en rises around a readback (≥1).
- READ_CYCLES, 5: cycles config_read / config_en_sram are held for a readback (≥1).
- SRAM_ADDR_HI, 8'h07: value driven on mem_config_addr[31:24] during SRAM readback.

Ports:
- clk_in  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  0=configure, 1=flush, 2=sram read, 3=reserved
- cmd_arg  in  16  configure: [12:0]=depth; sram read: [11:10]=bank, [9:0]=word
- rsp_valid  out  1  one-cycle pulse, readback data valid
- rsp_data  out  16  readback data
- mem_read_data  in  16  memory core config read data
- mem_clk_en  out  1  memory core clock enable
- mem_config_en  out  1  memory core config enable
- mem_config_write  out  1  config write strobe
- mem_config_read  out  1  config read strobe
- mem_config_en_sram  out  4  one-hot SRAM bank select
- mem_config_addr  out  32  config address
- mem_config_data  out  32  config write data
- mem_flush  out  1  line buffer flush
- stream_en  out  1  upstream producer may drive wen/data
- busy  out  1  state not IDLE/RUN

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; mem_clk_en=1; all other outputs 0, including cmd_ready and rsp_data.
  - Reset mid-operation aborts immediately; clk_en returns to 1 asynchronously.
- States: IDLE, CFG, SETTLE, RUN, FLUSH, RD_GATE, RD_ISSUE, RD_RESUME.
- cmd_ready=1 only in IDLE and RUN. A command is taken on the edge where cmd_valid&cmd_ready. cmd_op/cmd_arg are registered at acceptance.
- configure (from IDLE or RUN):
  - CFG lasts 1 cycle: mem_config_en=1, mem_config_write=1, addr=32'h0, data={16'b0, arg[12:0], 1'b1, 2'b00}. arg[15:13] is ignored; depth 0 is passed through.
  - SETTLE lasts 1 cycle with all config strobes 0.
  - Then RUN.
  - stream_en=0 in CFG/SETTLE and 1 in RUN. First RUN cycle is 2 cycles after acceptance.
- flush (from IDLE or RUN):
  - FLUSH lasts exactly FLUSH_CYCLES cycles with mem_flush=1, then returns to the origin state.
  - stream_en keeps its origin value during FLUSH.
- sram read (from IDLE or RUN):
  - Origin state is saved. stream_en=0 and mem_clk_en=0 from the cycle after acceptance.
  - RD_GATE: GATE_CYCLES cycles with strobes 0.
  - RD_ISSUE: READ_CYCLES cycles with mem_config_read=1, mem_config_en_sram=1<<arg[11:10], addr={SRAM_ADDR_HI, 14'b0, arg[9:0]}.
  - On the last RD_ISSUE cycle, rsp_data<=mem_read_data. rsp_valid pulses the following cycle, the first RD_RESUME cycle.
  - RD_RESUME: GATE_CYCLES cycles with clk_en still 0 and strobes 0. mem_clk_en=1 on return to origin; stream_en restores to its origin value.
- op 3: accepted, no state change, no response.
- rsp_data holds until the next readback.
- mem_config_addr/data return to 0 whenever their strobes are low.
- busy=1 in every state except IDLE and RUN.

Test Plan:
- Reset mid-readback (clk_en=0), deassert → mem_clk_en=1 immediately on assertion, state IDLE, cmd_ready=1 one cycle after release, rsp_valid=0.
- configure arg=10 from IDLE → one cycle of config_en=config_write=1, addr=0, data=32'h0000_0054; stream_en=1 two cycles after acceptance; cmd_ready=1 in RUN.
- flush in RUN → mem_flush=1 for exactly 3 cycles, stream_en stays 1, cmd_ready=0 for 3 cycles then 1.
- sram read arg=16'h0805 in RUN → clk_en=0 for 15 cycles; config_read=1 for 5 cycles with en_sram=4'b0100, addr=32'h0700_0005. With mem_read_data=16'h00AB on the last read cycle → rsp_valid pulse with rsp_data=16'h00AB. Then clk_en=1 and stream_en=1.
- Back-to-back: configure, then flush accepted on the first RUN cycle, then op 3 → flush completes; op 3 is accepted with no output change.
- Random cmd_valid/cmd_op traffic checked against a reference model → no strobe asserted while mem_clk_en=0 other than config_read/en_sram, and never config_write and config_read together.
